col_scale_deskew: RTL
=====================

# col_scale_deskew

Parametrised per-column post-processor between the systolic array and the output writeback. Each column's integer accumulator is scaled to FP16 with its own scale factor, optionally passed through ReLU, then deskewed from the array's diagonal wavefront into row-aligned output words. Scale updates are double-buffered and are applied only when the datapath is idle. Rows are counted into tiles and the last row of each tile is flagged.

## Interface
- COLS, 32, number of array columns (2..64)
- ACC_W, 32, accumulator width per column (8..32); sign-extended to 32 before scaling
- TILE_ROWS, 32, output rows per tile (>=1); drives `out_last`
---
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_data  in  COLS*ACC_W  column i at [(i+1)*ACC_W-1 : i*ACC_W], two's complement
- in_valid  in  COLS  per-column valid; column i lags column i-1 by one cycle (diagonal)
- deskew_en  in  1  1 = row-aligned output, 0 = diagonal pass-through; static while busy
- relu_en  in  1  1 = clamp negative results to +0; static while busy
- scale_wr  in  1  one-cycle strobe that loads `scale_wdata` into the shadow register
- scale_wdata  in  COLS*16  FP16 scale per column, column i at [(i+1)*16-1 : i*16]
- scale_pending  out  1  shadow register written but not yet applied
- busy  out  1  any in_valid high, or any valid bit in flight inside the block
- out_data  out  COLS*16  FP16 results, column i at [(i+1)*16-1 : i*16]
- out_valid  out  COLS  per-column valid; all bits equal when deskew_en=1
- out_last  out  1  qualifies the final row of a tile (deskew_en=1 only)

## Operation
- **Scale stage:** one existing `scale_unit` per column, 3-cycle latency, driven with reset `~rst`. Input: `in_data` column sign-extended to 32 bits. Scale: the active scale register for that column. Arithmetic is unchanged from `scale_unit`.
- **Stage 4 register:**
  - Captures the scale result.
  - If relu_en=1 and the sign bit is 1, it stores 16'h0000. This includes -0.
  - NaN with the sign bit set is also forced to 0.
- **Valid pipe:** per-column in_valid is delayed 4 cycles in lock-step with the data.
- **Deskew (deskew_en=1):**
  - Column i passes through an additional COLS-1-i register stages (shift registers of data + valid). Column COLS-1 gets zero extra stages.
  - `out_valid` is then all-ones or all-zeros per cycle. A mismatch is a protocol error; the bench checks for it.
- **Bypass (deskew_en=0):** deskew stages are skipped. Output equals the stage 4 register.
- **Scale double-buffer:**
  - `scale_wr`=1 writes the shadow register and sets `scale_pending`.
  - On any cycle with `scale_pending`=1 and `busy`=0, active ← shadow and `scale_pending` clears on the next edge.
  - If `scale_wr` and the apply condition coincide, the apply copies the *new* `scale_wdata`.
  - A second `scale_wr` before apply overwrites the shadow. Last write wins.
- **Tile row counter (deskew_en=1):**
  - Increments on each cycle where out_valid is all-ones.
  - `out_last`=1 when the counter equals TILE_ROWS-1; the counter then wraps to 0.
  - With deskew_en=0, `out_last`=0 and the counter holds.
- **Reset:**
  - All pipelines, valids, counter, `out_last`, `scale_pending` → 0.
  - Active and shadow scales → 16'h3C00 (1.0) in every column.
  - `out_data` → 0.
  - Reset mid-stream drops all in-flight rows with no partial output.

## Timing
- Latency, deskew_en=0: column i output valid 4 cycles after its in_valid.
- Latency, deskew_en=1: row r, column i entering at t0+r+i leaves for every column at t0+r+COLS+3.
- Throughput: one row per cycle, with no stalls and no backpressure.
- `busy` is combinational from in_valid and the pipeline valid bits.
- Scale apply is at the earliest 1 cycle after the last out_valid.
- Output data is don't-care while the corresponding out_valid=0. The bench masks it.

## Test plan
- **Reset defaults:** rst pulse, then COLS=4 rows of in_data=5 per column with deskew_en=1 → out_data every column 16'h4500 (5.0), all valid at t0+r+7, out_last=0 (TILE_ROWS=32).
- **Per-column scale:**
  - Steps: idle write scale_wdata col0=16'h4000 (2.0), col1=16'h3800 (0.5); stream in_data=8.
  - Expect: col0 out 16'h4C00, col1 16'h4400; scale_pending high 1 cycle.
- **Deferred apply:** scale_wr mid-stream → scale_pending stays 1, in-flight rows use old scale, new scale active only after busy falls; next stream uses new value.
- **ReLU:** relu_en=1, in_data=-3, scale 1.0 → out 16'h0000; relu_en=0 → 16'hC200.
- **Bypass skew:** deskew_en=0, COLS=4 diagonal input → out_valid bit i rises at t0+i+4; out_last stays 0.
- **Tile wrap and reset:**
  - Steps: TILE_ROWS=3, 7 rows; then assert rst during a second stream.
  - Expect: out_last on rows 2 and 5 only.
  - After rst, out_valid=0 immediately, with no stale rows after release.

Source files
------------

// File: rtl/col_scale_deskew.sv
// col_scale_deskew: per-column int->FP16 scaling, optional ReLU, and deskew of
// the systolic array's diagonal wavefront into row-aligned output words.
// Also holds scale_unit, the 3-cycle signed-integer x FP16 -> FP16 multiplier.

module scale_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_acc,
  input  logic [15:0] i_scale,
  output logic [15:0] o_res
);
  logic        r1_sign, r1_inf, r1_nan;
  logic [31:0] r1_mag;
  logic [10:0] r1_man;
  logic [5:0]  r1_exp;
  logic        r2_sign, r2_inf, r2_nan;
  logic [41:0] r2_prod;
  logic [5:0]  r2_exp;
  logic [15:0] r_res;

  logic [5:0]        w_lead;
  logic [5:0]        w_shift;
  logic [41:0]       w_norm;
  logic [9:0]        w_mant;
  logic              w_rnd;
  logic signed [7:0] w_bexp;
  logic [16:0]       w_sum;
  logic [15:0]       w_res;

  // Stage 1: split the accumulator into sign/magnitude and unpack the FP16 scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_sign <= 1'b0;
      r1_mag  <= 32'd0;
      r1_man  <= 11'd0;
      r1_exp  <= 6'd0;
      r1_inf  <= 1'b0;
      r1_nan  <= 1'b0;
    end else begin
      r1_sign <= i_acc[31] ^ i_scale[15];
      r1_mag  <= i_acc[31] ? (32'd0 - i_acc) : i_acc;
      r1_man  <= {(i_scale[14:10] != 5'd0), i_scale[9:0]};
      r1_exp  <= (i_scale[14:10] == 5'd0) ? 6'd1 : {1'b0, i_scale[14:10]};
      r1_inf  <= (i_scale[14:10] == 5'h1F) && (i_scale[9:0] == 10'd0);
      r1_nan  <= (i_scale[14:10] == 5'h1F) && (i_scale[9:0] != 10'd0);
    end
  end

  // Stage 2: integer product of magnitude and scale significand (always < 2^42).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_sign <= 1'b0;
      r2_prod <= 42'd0;
      r2_exp  <= 6'd0;
      r2_inf  <= 1'b0;
      r2_nan  <= 1'b0;
    end else begin
      r2_sign <= r1_sign;
      r2_prod <= {10'd0, r1_mag} * {31'd0, r1_man};
      r2_exp  <= r1_exp;
      r2_inf  <= r1_inf;
      r2_nan  <= r1_nan;
    end
  end

  // Leading-one search over the product.
  always_comb begin
    w_lead = 6'd0;
    for (int k = 0; k < 42; k++) begin
      if (r2_prod[k]) w_lead = 6'(k);
      else            w_lead = w_lead;
    end
  end

  // Normalise, round to nearest even, and pack with overflow/underflow handling.
  // Bit 41 of the normalised product is the hidden one; it is zero only for a zero product.
  always_comb begin
    w_shift = 6'd41 - w_lead;
    w_norm  = r2_prod << w_shift;
    w_mant  = w_norm[40:31];
    w_rnd   = w_norm[30] & ((|w_norm[29:0]) | w_mant[0]);
    w_bexp  = $signed({2'b00, w_lead}) + $signed({2'b00, r2_exp}) - 8'sd10;
    w_sum   = {w_bexp[6:0], w_mant} + {16'd0, w_rnd};
    if (r2_nan || (r2_inf && !w_norm[41])) begin
      w_res = {r2_sign, 15'h7E00};
    end else if (r2_inf) begin
      w_res = {r2_sign, 15'h7C00};
    end else if (!w_norm[41] || (w_bexp <= 8'sd0)) begin
      w_res = {r2_sign, 15'h0000};
    end else if (w_sum[16:10] >= 7'd31) begin
      w_res = {r2_sign, 15'h7C00};
    end else begin
      w_res = {r2_sign, w_sum[14:0]};
    end
  end

  // Stage 3: register the packed FP16 result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_res <= 16'h0000;
    else        r_res <= w_res;
  end

  assign o_res = r_res;
endmodule

module col_scale_deskew #(
  parameter int COLS      = 32,
  parameter int ACC_W     = 32,
  parameter int TILE_ROWS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLS*ACC_W-1:0] in_data,
  input  logic [COLS-1:0]       in_valid,
  input  logic                  deskew_en,
  input  logic                  relu_en,
  input  logic                  scale_wr,
  input  logic [COLS*16-1:0]    scale_wdata,
  output logic                  scale_pending,
  output logic                  busy,
  output logic [COLS*16-1:0]    out_data,
  output logic [COLS-1:0]       out_valid,
  output logic                  out_last
);
  localparam int CW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(TILE_ROWS - 1);

  logic                 w_rst_n;
  logic [COLS*16-1:0]   r_scale_act, r_scale_shd;
  logic                 r_scale_pending;
  logic [COLS-1:0]      r_v1, r_v2, r_v3, r_s4_valid;
  logic [COLS-1:0]      w_dsk_busy;
  logic [CW-1:0]        r_row_cnt;
  logic                 w_all_valid;
  logic                 w_apply;

  assign w_rst_n = ~rst;

  // Valid pipe tracking the 3-cycle scale unit plus the stage 4 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1       <= '0;
      r_v2       <= '0;
      r_v3       <= '0;
      r_s4_valid <= '0;
    end else begin
      r_v1       <= in_valid;
      r_v2       <= r_v1;
      r_v3       <= r_v2;
      r_s4_valid <= r_v3;
    end
  end

  for (genvar i = 0; i < COLS; i++) begin : g_col
    localparam int DEPTH = COLS - 1 - i;
    logic [31:0] w_acc_ext;
    logic [15:0] w_su_res;
    logic [15:0] r_s4_d;
    logic [15:0] w_tail_d;
    logic        w_tail_v;

    assign w_acc_ext = 32'($signed(in_data[i*ACC_W +: ACC_W]));

    scale_unit u_scale (
      .clk     (clk),
      .rst_n   (w_rst_n),
      .i_acc   (w_acc_ext),
      .i_scale (r_scale_act[i*16 +: 16]),
      .o_res   (w_su_res)
    );

    // Stage 4: capture the scaled value, clamping any sign-set result under ReLU.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                        r_s4_d <= 16'h0000;
      else if (relu_en && w_su_res[15]) r_s4_d <= 16'h0000;
      else                            r_s4_d <= w_su_res;
    end

    if (DEPTH == 0) begin : g_nodly
      assign w_tail_d      = r_s4_d;
      assign w_tail_v      = r_s4_valid[i];
      assign w_dsk_busy[i] = 1'b0;
    end else begin : g_dly
      logic [15:0]      r_dsk_d [DEPTH];
      logic [DEPTH-1:0] r_dsk_v;

      // Deskew shift register: earlier columns wait for the last column to catch up.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) r_dsk_d[k] <= 16'h0000;
          r_dsk_v <= '0;
        end else begin
          r_dsk_d[0] <= r_s4_d;
          r_dsk_v[0] <= r_s4_valid[i];
          for (int k = 1; k < DEPTH; k++) begin
            r_dsk_d[k] <= r_dsk_d[k-1];
            r_dsk_v[k] <= r_dsk_v[k-1];
          end
        end
      end

      assign w_tail_d      = r_dsk_d[DEPTH-1];
      assign w_tail_v      = r_dsk_v[DEPTH-1];
      assign w_dsk_busy[i] = |r_dsk_v;
    end

    assign out_data[i*16 +: 16] = deskew_en ? w_tail_d : r_s4_d;
    assign out_valid[i]         = deskew_en ? w_tail_v : r_s4_valid[i];
  end

  assign busy = (|in_valid) | (|r_v1) | (|r_v2) | (|r_v3) | (|r_s4_valid) | (|w_dsk_busy);
  assign w_apply = r_scale_pending & ~busy;
  assign scale_pending = r_scale_pending;

  // Scale double-buffer: shadow takes writes, active is only swapped while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scale_act     <= {COLS{16'h3C00}};
      r_scale_shd     <= {COLS{16'h3C00}};
      r_scale_pending <= 1'b0;
    end else begin
      if (scale_wr) r_scale_shd <= scale_wdata;
      else          r_scale_shd <= r_scale_shd;
      if (w_apply) begin
        r_scale_act     <= scale_wr ? scale_wdata : r_scale_shd;
        r_scale_pending <= 1'b0;
      end else if (scale_wr) begin
        r_scale_pending <= 1'b1;
      end else begin
        r_scale_pending <= r_scale_pending;
      end
    end
  end

  assign w_all_valid = &out_valid;
  assign out_last    = deskew_en & w_all_valid & (r_row_cnt == LAST_ROW);

  // Tile row counter: advances on each aligned output row, wraps after the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      r_row_cnt <= '0;
    else if (deskew_en && w_all_valid && (r_row_cnt == LAST_ROW)) r_row_cnt <= '0;
    else if (deskew_en && w_all_valid)            r_row_cnt <= r_row_cnt + 1'b1;
    else                                          r_row_cnt <= r_row_cnt;
  end
endmodule
